scene_sequencer: RTL and testbench
==================================

SCENE_SEQUENCER -- requirements
Module: scene_sequencer

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255, max OBJ_ACK wait in cycles (only with SCENE_SEQ_TIMEOUT_EN).
REQ-002 ACLK  input  1  sole clock; all logic on rising edge.
REQ-003 ARESET  input  1  reset, synchronous, active-high.
REQ-004 START  input  1  one-cycle request to begin a frame.
REQ-005 RDATA  input  8  header byte stream.
REQ-006 RVALID  input  1  RDATA valid.
REQ-007 RREADY  output  1  sequencer accepts RDATA; byte consumed when RVALID&RREADY.
REQ-008 X_CENTER, Y_CENTER, ANGLE, ZOOM  output  8 each  latched header fields.
REQ-009 OBJ_COUNT  output  8  latched object count.
REQ-010 HDR_VALID  output  1  header fields stable and valid.
REQ-011 OBJ_REQ  output  1  object dispatch request.
REQ-012 OBJ_INDEX  output  8  index of requested object, 0..OBJ_COUNT-1.
REQ-013 OBJ_ACK  input  1  object processed; completes handshake when OBJ_REQ high.
REQ-014 BUSY  output  1  high in any state except IDLE.
REQ-015 DONE  output  1  one-cycle pulse at frame completion.
REQ-016 ERR  output  1  sticky timeout flag (0 constant without SCENE_SEQ_TIMEOUT_EN).

Function
REQ-017 States: IDLE, HDR, DISPATCH, FIN; registered state, single always-block next-state decode.
REQ-018 IDLE: RREADY=0, OBJ_REQ=0; START=1 -> HDR next cycle, HDR_VALID cleared, byte counter=0.
REQ-019 HDR: RREADY=1; accepted bytes stored in order OBJ_COUNT, X_CENTER, Y_CENTER, ANGLE, ZOOM; counter 0..4 advances only on accept.
REQ-020 RVALID low in HDR: stall, no field or counter change.
REQ-021 Accept of byte 4: HDR_VALID=1 next cycle; OBJ_COUNT=0 -> FIN, else -> DISPATCH with OBJ_INDEX=0.
REQ-022 DISPATCH: OBJ_REQ=1 and OBJ_INDEX held until OBJ_ACK; OBJ_ACK ignored when OBJ_REQ=0.
REQ-023 OBJ_ACK in DISPATCH: OBJ_INDEX==OBJ_COUNT-1 -> FIN (OBJ_REQ low next cycle); else OBJ_INDEX+1, OBJ_REQ stays high (back-to-back, one object per cycle max).
REQ-024 FIN: DONE=1 for exactly one cycle, then IDLE; header fields and HDR_VALID retained until next START.
REQ-025 START while BUSY: ignored, no restart.
REQ-026 OBJ_COUNT=255: indices 0..254 dispatched, no wrap of OBJ_INDEX.
REQ-027 START and ARESET same cycle: reset wins.

Reset
REQ-028 ARESET=1 on any edge: state IDLE, counter 0, all outputs 0 (RREADY, OBJ_REQ, OBJ_INDEX, header fields, OBJ_COUNT, HDR_VALID, BUSY, DONE, ERR).
REQ-029 Reset mid-HDR or mid-DISPATCH: abandon frame, no DONE pulse, next frame requires new START.

Configuration
REQ-030 Macro SCENE_SEQ_TIMEOUT_EN defined: watchdog counts cycles OBJ_REQ high without OBJ_ACK; reaching TIMEOUT_CYCLES sets ERR=1, drops OBJ_REQ, -> FIN (DONE pulses); counter clears on each ACK; ERR clears only on START or reset.
REQ-031 Macro undefined: no watchdog logic, DISPATCH waits indefinitely, ERR tied 0.

Verification
REQ-032 Reset, START, bytes 03,10,20,30,40 back-to-back -> fields 10/20/30/40, OBJ_COUNT=3, OBJ_INDEX 0,1,2 with ACK each, DONE one cycle after third ACK, BUSY low after.
REQ-033 Header with count 00 -> HDR_VALID=1, no OBJ_REQ, DONE pulse, IDLE.
REQ-034 RVALID toggled 1/0 every cycle during header -> same field values as REQ-032, 10 cycles to load.
REQ-035 START pulsed during DISPATCH, OBJ_ACK pulsed in IDLE -> no state or index change.
REQ-036 ARESET asserted after OBJ_INDEX=1 acknowledged -> all outputs 0 next cycle, no DONE; fresh frame completes normally.
REQ-037 SCENE_SEQ_TIMEOUT_EN, TIMEOUT_CYCLES=8, OBJ_ACK never asserted -> ERR=1, OBJ_REQ low, DONE pulse after 8 waiting cycles; without macro OBJ_REQ held 100+ cycles, ERR=0.

Source files
------------

// File: rtl/scene_sequencer.sv
// Scene sequencer: loads a five-byte frame header, then dispatches OBJ_COUNT object requests.
// Optional OBJ_ACK watchdog enabled by defining SCENE_SEQ_TIMEOUT_EN.
module scene_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic       ACLK,
  input  logic       ARESET,
  input  logic       START,
  input  logic [7:0] RDATA,
  input  logic       RVALID,
  output logic       RREADY,
  output logic [7:0] X_CENTER,
  output logic [7:0] Y_CENTER,
  output logic [7:0] ANGLE,
  output logic [7:0] ZOOM,
  output logic [7:0] OBJ_COUNT,
  output logic       HDR_VALID,
  output logic       OBJ_REQ,
  output logic [7:0] OBJ_INDEX,
  input  logic       OBJ_ACK,
  output logic       BUSY,
  output logic       DONE,
  output logic       ERR
);

  typedef enum logic [1:0] {S_IDLE, S_HDR, S_DISPATCH, S_FIN} state_t;

  state_t     state, state_nxt;
  logic [2:0] byte_cnt;
  logic       start_ok, hdr_acc, hdr_last, obj_ack_ok, obj_last, timeout;

  always_ff @(posedge ACLK) begin
    if (ARESET) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    RREADY     = 1'b0;
    OBJ_REQ    = 1'b0;
    BUSY       = 1'b1;
    DONE       = 1'b0;
    start_ok   = 1'b0;
    hdr_acc    = 1'b0;
    hdr_last   = 1'b0;
    obj_ack_ok = 1'b0;
    obj_last   = (OBJ_INDEX == OBJ_COUNT - 8'd1);
    case (state)
      S_IDLE: begin
        BUSY = 1'b0;
        if (START) begin
          start_ok  = 1'b1;
          state_nxt = S_HDR;
        end
      end
      S_HDR: begin
        RREADY = 1'b1;
        if (RVALID) begin
          hdr_acc = 1'b1;
          if (byte_cnt == 3'd4) begin
            hdr_last  = 1'b1;
            // OBJ_COUNT was captured from byte 0 and is already registered here
            state_nxt = (OBJ_COUNT == 8'd0) ? S_FIN : S_DISPATCH;
          end
        end
      end
      S_DISPATCH: begin
        OBJ_REQ = 1'b1;
        if (OBJ_ACK) begin
          obj_ack_ok = 1'b1;
          if (obj_last) state_nxt = S_FIN;
        end else if (timeout) begin
          state_nxt = S_FIN;
        end
      end
      S_FIN: begin
        DONE      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      byte_cnt  <= 3'd0;
      OBJ_COUNT <= 8'd0;
      X_CENTER  <= 8'd0;
      Y_CENTER  <= 8'd0;
      ANGLE     <= 8'd0;
      ZOOM      <= 8'd0;
      HDR_VALID <= 1'b0;
      OBJ_INDEX <= 8'd0;
    end else begin
      if (start_ok) begin
        byte_cnt  <= 3'd0;
        HDR_VALID <= 1'b0;
      end
      if (hdr_acc) begin
        case (byte_cnt)
          3'd0:    OBJ_COUNT <= RDATA;
          3'd1:    X_CENTER  <= RDATA;
          3'd2:    Y_CENTER  <= RDATA;
          3'd3:    ANGLE     <= RDATA;
          default: ZOOM      <= RDATA;
        endcase
        if (!hdr_last) byte_cnt <= byte_cnt + 3'd1;
      end
      if (hdr_last) begin
        HDR_VALID <= 1'b1;
        OBJ_INDEX <= 8'd0;
      end
      if (obj_ack_ok && !obj_last) OBJ_INDEX <= OBJ_INDEX + 8'd1;
    end
  end

`ifdef SCENE_SEQ_TIMEOUT_EN
  localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [WD_W-1:0] wd_cnt;

  // Fires on the TIMEOUT_CYCLES-th consecutive cycle of OBJ_REQ without OBJ_ACK
  assign timeout = (state == S_DISPATCH) && !OBJ_ACK &&
                   (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      wd_cnt <= '0;
      ERR    <= 1'b0;
    end else begin
      if (state != S_DISPATCH || OBJ_ACK) wd_cnt <= '0;
      else                                wd_cnt <= wd_cnt + 1'b1;
      if (start_ok)     ERR <= 1'b0;
      else if (timeout) ERR <= 1'b1;
    end
  end
`else
  // TIMEOUT_CYCLES has no effect without the watchdog
  localparam int unsigned unused_timeout_cycles = TIMEOUT_CYCLES;

  assign timeout = 1'b0;
  assign ERR     = 1'b0;
`endif

endmodule

// File: tb/tb_scene_sequencer.sv
// Directed bench for scene_sequencer; timeout scenario follows SCENE_SEQ_TIMEOUT_EN.
module tb_scene_sequencer;

  logic       ACLK = 1'b0;
  logic       ARESET, START, RVALID, OBJ_ACK;
  logic [7:0] RDATA;
  logic       RREADY, HDR_VALID, OBJ_REQ, BUSY, DONE, ERR;
  logic [7:0] X_CENTER, Y_CENTER, ANGLE, ZOOM, OBJ_COUNT, OBJ_INDEX;

  int n_checks = 0;
  int n_errors = 0;

  scene_sequencer #(.TIMEOUT_CYCLES(8)) dut (
    .ACLK(ACLK), .ARESET(ARESET), .START(START), .RDATA(RDATA), .RVALID(RVALID),
    .RREADY(RREADY), .X_CENTER(X_CENTER), .Y_CENTER(Y_CENTER), .ANGLE(ANGLE),
    .ZOOM(ZOOM), .OBJ_COUNT(OBJ_COUNT), .HDR_VALID(HDR_VALID), .OBJ_REQ(OBJ_REQ),
    .OBJ_INDEX(OBJ_INDEX), .OBJ_ACK(OBJ_ACK), .BUSY(BUSY), .DONE(DONE), .ERR(ERR)
  );

  always #5 ACLK = ~ACLK;

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_hdr(input logic [7:0] b0, b1, b2, b3, b4);
    logic [7:0] bytes [5];
    bytes = '{b0, b1, b2, b3, b4};
    for (int i = 0; i < 5; i++) begin
      RDATA  = bytes[i];
      RVALID = 1'b1;
      tick();
    end
    RVALID = 1'b0;
  endtask

  task automatic do_start();
    START = 1'b1;
    tick();
    START = 1'b0;
  endtask

  initial begin
    ARESET = 1'b1; START = 1'b0; RVALID = 1'b0; OBJ_ACK = 1'b0; RDATA = 8'h00;
    tick();
    tick();
    chk("rst_busy", BUSY, 0);      chk("rst_rready", RREADY, 0);
    chk("rst_objreq", OBJ_REQ, 0); chk("rst_idx", OBJ_INDEX, 0);
    chk("rst_hdrv", HDR_VALID, 0); chk("rst_done", DONE, 0);
    chk("rst_err", ERR, 0);        chk("rst_cnt", OBJ_COUNT, 0);
    chk("rst_fields", {X_CENTER, Y_CENTER, ANGLE, ZOOM}, 32'h0);

    // START with reset in the same cycle: reset wins
    START = 1'b1;
    tick();
    START = 1'b0; ARESET = 1'b0;
    chk("start_rst_busy", BUSY, 0);
    tick();
    chk("start_rst_idle", BUSY, 0);

    // Basic frame, three objects
    do_start();
    chk("f1_busy", BUSY, 1); chk("f1_rready", RREADY, 1); chk("f1_hdrv0", HDR_VALID, 0);
    send_hdr(8'h03, 8'h10, 8'h20, 8'h30, 8'h40);
    chk("f1_hdrv", HDR_VALID, 1);
    chk("f1_fields", {X_CENTER, Y_CENTER, ANGLE, ZOOM}, 32'h10203040);
    chk("f1_cnt", OBJ_COUNT, 8'h03);
    chk("f1_req", OBJ_REQ, 1); chk("f1_idx0", OBJ_INDEX, 0); chk("f1_rready0", RREADY, 0);
    tick(); tick();
    chk("f1_hold_idx", OBJ_INDEX, 0); chk("f1_hold_req", OBJ_REQ, 1);
    OBJ_ACK = 1'b1;
    tick();
    chk("f1_idx1", OBJ_INDEX, 1); chk("f1_req1", OBJ_REQ, 1); chk("f1_done_n", DONE, 0);
    tick();
    chk("f1_idx2", OBJ_INDEX, 2);
    tick();
    OBJ_ACK = 1'b0;
    chk("f1_done", DONE, 1); chk("f1_req_lo", OBJ_REQ, 0); chk("f1_idx_hold", OBJ_INDEX, 2);
    tick();
    chk("f1_done_1cyc", DONE, 0); chk("f1_idle", BUSY, 0); chk("f1_hdrv_keep", HDR_VALID, 1);
    chk("f1_fields_keep", {X_CENTER, Y_CENTER, ANGLE, ZOOM}, 32'h10203040);

    // Zero-object frame
    do_start();
    chk("f0_hdrv_clr", HDR_VALID, 0);
    send_hdr(8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD);
    chk("f0_done", DONE, 1); chk("f0_hdrv", HDR_VALID, 1); chk("f0_req", OBJ_REQ, 0);
    chk("f0_fields", {X_CENTER, Y_CENTER, ANGLE, ZOOM}, 32'hAABBCCDD);
    tick();
    chk("f0_idle", BUSY, 0); chk("f0_done_lo", DONE, 0); chk("f0_req2", OBJ_REQ, 0);

    // RVALID toggling 1/0: accepts on cycles 1,3,5,7,9
    do_start();
    for (int i = 0; i < 10; i++) begin
      RVALID = (i % 2 == 0);
      case (i)
        0: RDATA = 8'h03;
        2: RDATA = 8'h10;
        4: RDATA = 8'h20;
        6: RDATA = 8'h30;
        8: RDATA = 8'h40;
        default: RDATA = 8'hEE;
      endcase
      tick();
      if (i == 1) begin
        chk("tg_stall_x", X_CENTER, 8'hAA); chk("tg_cnt", OBJ_COUNT, 8'h03);
      end
      if (i == 7) begin
        chk("tg_stall_zoom", ZOOM, 8'hDD); chk("tg_hdrv0", HDR_VALID, 0);
        chk("tg_angle", ANGLE, 8'h30);
      end
    end
    RVALID = 1'b0;
    chk("tg_fields", {X_CENTER, Y_CENTER, ANGLE, ZOOM}, 32'h10203040);
    chk("tg_hdrv", HDR_VALID, 1); chk("tg_req", OBJ_REQ, 1); chk("tg_idx", OBJ_INDEX, 0);

    // START during DISPATCH is ignored
    do_start();
    chk("sb_busy", BUSY, 1); chk("sb_req", OBJ_REQ, 1);
    chk("sb_rready", RREADY, 0); chk("sb_idx", OBJ_INDEX, 0);
    OBJ_ACK = 1'b1;
    tick(); tick(); tick();
    OBJ_ACK = 1'b0;
    chk("sb_done", DONE, 1);
    tick();
    // OBJ_ACK in IDLE is ignored
    OBJ_ACK = 1'b1;
    tick();
    OBJ_ACK = 1'b0;
    chk("ai_idx", OBJ_INDEX, 2); chk("ai_busy", BUSY, 0); chk("ai_req", OBJ_REQ, 0);

    // Reset mid-DISPATCH after index 1 is acknowledged
    do_start();
    send_hdr(8'h03, 8'h10, 8'h20, 8'h30, 8'h40);
    OBJ_ACK = 1'b1;
    tick(); tick();
    OBJ_ACK = 1'b0;
    chk("rm_idx2", OBJ_INDEX, 2);
    ARESET = 1'b1;
    tick();
    ARESET = 1'b0;
    chk("rm_done", DONE, 0); chk("rm_busy", BUSY, 0); chk("rm_req", OBJ_REQ, 0);
    chk("rm_idx", OBJ_INDEX, 0); chk("rm_hdrv", HDR_VALID, 0); chk("rm_cnt", OBJ_COUNT, 0);
    chk("rm_fields", {X_CENTER, Y_CENTER, ANGLE, ZOOM}, 32'h0);
    tick();
    chk("rm_no_restart", BUSY, 0); chk("rm_done2", DONE, 0);
    do_start();
    send_hdr(8'h02, 8'h01, 8'h02, 8'h03, 8'h04);
    chk("rm_fresh_req", OBJ_REQ, 1);
    OBJ_ACK = 1'b1;
    tick();
    chk("rm_fresh_idx", OBJ_INDEX, 1);
    tick();
    OBJ_ACK = 1'b0;
    chk("rm_fresh_done", DONE, 1);
    chk("rm_fresh_fields", {X_CENTER, Y_CENTER, ANGLE, ZOOM}, 32'h01020304);
    tick();

    // 255 objects, ACK held high: indices 0..254, no wrap
    do_start();
    send_hdr(8'hFF, 8'h11, 8'h22, 8'h33, 8'h44);
    OBJ_ACK = 1'b1;
    for (int i = 0; i < 254; i++) tick();
    chk("c255_idx", OBJ_INDEX, 8'd254); chk("c255_req", OBJ_REQ, 1);
    tick();
    OBJ_ACK = 1'b0;
    chk("c255_done", DONE, 1); chk("c255_nowrap", OBJ_INDEX, 8'd254);
    tick();

    // No OBJ_ACK ever
    do_start();
    send_hdr(8'h01, 8'h05, 8'h06, 8'h07, 8'h08);
`ifdef SCENE_SEQ_TIMEOUT_EN
    for (int i = 0; i < 7; i++) tick();
    chk("to_req7", OBJ_REQ, 1); chk("to_err7", ERR, 0);
    tick();
    chk("to_done", DONE, 1); chk("to_err", ERR, 1); chk("to_req_lo", OBJ_REQ, 0);
    tick();
    chk("to_err_sticky", ERR, 1); chk("to_idle", BUSY, 0);
    do_start();
    chk("to_err_clr", ERR, 0);
    ARESET = 1'b1;
    tick();
    ARESET = 1'b0;
`else
    for (int i = 0; i < 120; i++) tick();
    chk("nt_req", OBJ_REQ, 1); chk("nt_err", ERR, 0); chk("nt_done", DONE, 0);
    OBJ_ACK = 1'b1;
    tick();
    OBJ_ACK = 1'b0;
    chk("nt_done_ack", DONE, 1); chk("nt_err2", ERR, 0);
    tick();
`endif
    chk("end_idle", BUSY, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
